// File: rtl/crc_mem_pkg.sv
// Shared types and default widths for the CRC memory scrubber slice.
package crc_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WB     = 2'd1,
      SETTLE = 2'd2,
      FAULT  = 2'd3
   } scrub_state_e;

   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 8;
   localparam int SETTLE_W   = 4;

endpackage

// File: rtl/crc_err_counter.sv
// Saturating event counter with synchronous clear; a clear coinciding with
// an increment leaves the count at one.
module crc_err_counter
   import crc_mem_pkg::*;
#(
   parameter int CNT_WIDTH = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= inc ? CNT_WIDTH'(1) : '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/crc_mem_scrubber.sv
// Write-side controller for the CRC-protected memory stage: host writes, scrub
// write-backs of corrected words, sticky fault. Error counters: CRC_SCRUB_ERR_CNT_EN.
module crc_mem_scrubber
   import crc_mem_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_W_DEF,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_WIDTH     = CNT_W_DEF,
   parameter int CORR_THRESH   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  host_valid,
   input  logic [DATA_WIDTH-1:0] host_data,
   output logic                  host_ready,
   output logic                  mem_wr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic                  err_detected,
   input  logic                  err_corrected,
   input  logic                  fault_clr,
   output logic                  fault,
   output logic                  scrub_busy,
   output logic [CNT_WIDTH-1:0]  corr_cnt,
   output logic [CNT_WIDTH-1:0]  uncorr_cnt,
   output logic                  alarm
);

   localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || CORR_THRESH < 1) begin : g_param_check
      $error("crc_mem_scrubber: SETTLE_CYCLES must be 1..15 and CORR_THRESH >= 1");
   end

   scrub_state_e          state, state_nxt;
   logic [SETTLE_W-1:0]   settle_cnt, settle_nxt;
   logic [DATA_WIDTH-1:0] wb_data, wb_nxt;
   logic                  host_fire;
   logic                  enter_wb;
   logic                  enter_fault;

   assign host_fire = host_valid && (state != WB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SETTLE;
         settle_cnt <= SETTLE_INIT;
         wb_data    <= '0;
         fault      <= 1'b0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
         wb_data    <= wb_nxt;
         fault      <= enter_fault || (fault && !fault_clr);
      end
   end

   // A host write always wins over error handling; WB lasts exactly one cycle.
   always_comb begin
      state_nxt   = state;
      settle_nxt  = settle_cnt;
      wb_nxt      = wb_data;
      enter_wb    = 1'b0;
      enter_fault = 1'b0;
      if (state == WB || host_fire) begin
         state_nxt  = SETTLE;
         settle_nxt = SETTLE_INIT;
      end else begin
         case (state)
            SETTLE: begin
               if (settle_cnt <= SETTLE_W'(1)) begin
                  state_nxt = IDLE;
               end else begin
                  settle_nxt = settle_cnt - SETTLE_W'(1);
               end
            end
            IDLE: begin
               if (err_detected && err_corrected) begin
                  wb_nxt    = mem_data_out;
                  state_nxt = WB;
                  enter_wb  = 1'b1;
               end else if (err_detected) begin
                  state_nxt   = FAULT;
                  enter_fault = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      host_ready  = (state != WB);
      scrub_busy  = (state == WB);
      mem_wr      = host_fire || (state == WB);
      mem_data_in = '0;
      if (host_fire) begin
         mem_data_in = host_data;
      end else if (state == WB) begin
         mem_data_in = wb_data;
      end
   end

`ifdef CRC_SCRUB_ERR_CNT_EN
   localparam logic [CNT_WIDTH-1:0] THRESH = CNT_WIDTH'(CORR_THRESH);

   crc_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_corr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (fault_clr),
      .inc   (enter_wb),
      .count (corr_cnt)
   );

   crc_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_uncorr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (fault_clr),
      .inc   (enter_fault),
      .count (uncorr_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm <= 1'b0;
      end else begin
         alarm <= (corr_cnt >= THRESH);
      end
   end
`else
   assign corr_cnt   = '0;
   assign uncorr_cnt = '0;
   assign alarm      = 1'b0;
`endif

endmodule

// File: tb/tb_crc_mem_scrubber.sv
// Directed plus randomized bench for crc_mem_scrubber against a cycle-level
// behavioural model of the write/settle/scrub/fault rules.
module tb_crc_mem_scrubber;

   localparam int DW = 8;
   localparam int SC = 2;
   localparam int CW = 8;
   localparam int TH = 16;
   localparam int CNT_MAX = (1 << CW) - 1;
`ifdef CRC_SCRUB_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          host_valid;
   logic [DW-1:0] host_data;
   logic          host_ready;
   logic          mem_wr;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out;
   logic          err_detected;
   logic          err_corrected;
   logic          fault_clr;
   logic          fault;
   logic          scrub_busy;
   logic [CW-1:0] corr_cnt;
   logic [CW-1:0] uncorr_cnt;
   logic          alarm;

   int checks = 0;
   int errors = 0;

   // Reference model: remaining ignore cycles, pending write-back, fault mode.
   int          m_quiet;
   bit          m_wbp;
   logic [DW-1:0] m_wb;
   bit          m_fmode;
   bit          m_fault;
   int          m_corr;
   int          m_uncorr;
   bit          m_alarm;

   crc_mem_scrubber #(
      .DATA_WIDTH    (DW),
      .SETTLE_CYCLES (SC),
      .CNT_WIDTH     (CW),
      .CORR_THRESH   (TH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .host_valid    (host_valid),
      .host_data     (host_data),
      .host_ready    (host_ready),
      .mem_wr        (mem_wr),
      .mem_data_in   (mem_data_in),
      .mem_data_out  (mem_data_out),
      .err_detected  (err_detected),
      .err_corrected (err_corrected),
      .fault_clr     (fault_clr),
      .fault         (fault),
      .scrub_busy    (scrub_busy),
      .corr_cnt      (corr_cnt),
      .uncorr_cnt    (uncorr_cnt),
      .alarm         (alarm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_quiet  = SC;
      m_wbp    = 1'b0;
      m_wb     = '0;
      m_fmode  = 1'b0;
      m_fault  = 1'b0;
      m_corr   = 0;
      m_uncorr = 0;
      m_alarm  = 1'b0;
   endtask

   task automatic check_outputs();
      bit            rdy;
      bit            fire;
      logic [DW-1:0] exp_data;
      rdy  = !m_wbp;
      fire = (host_valid === 1'b1) && rdy;
      exp_data = fire ? host_data : (m_wbp ? m_wb : '0);
      chk("host_ready", 32'(host_ready), 32'(rdy));
      chk("mem_wr", 32'(mem_wr), 32'(fire || m_wbp));
      chk("mem_data_in", 32'(mem_data_in), 32'(exp_data));
      chk("scrub_busy", 32'(scrub_busy), 32'(m_wbp));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
      chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
      chk("alarm", 32'(alarm), 32'(m_alarm));
   endtask

   task automatic model_update(input bit hv, input bit det, input bit cor,
                               input logic [DW-1:0] mdo, input bit clr);
      bit fire;
      bit inc_c;
      bit inc_u;
      bit set_f;
      bit new_alarm;
      fire  = hv && !m_wbp;
      inc_c = 1'b0;
      inc_u = 1'b0;
      set_f = 1'b0;
      new_alarm = CNT_EN && (m_corr >= TH);
      if (m_wbp) begin
         m_wbp   = 1'b0;
         m_quiet = SC;
      end else if (fire) begin
         m_quiet = SC;
         m_fmode = 1'b0;
      end else if (m_quiet > 0) begin
         m_quiet--;
      end else if (!m_fmode && det && cor) begin
         m_wbp = 1'b1;
         m_wb  = mdo;
         inc_c = 1'b1;
      end else if (!m_fmode && det) begin
         m_fmode = 1'b1;
         set_f   = 1'b1;
         inc_u   = 1'b1;
      end
      m_fault = set_f || (m_fault && !clr);
      if (CNT_EN) begin
         if (clr) begin
            m_corr   = int'(inc_c);
            m_uncorr = int'(inc_u);
         end else begin
            if (inc_c && m_corr < CNT_MAX) m_corr++;
            if (inc_u && m_uncorr < CNT_MAX) m_uncorr++;
         end
      end
      m_alarm = new_alarm;
   endtask

   task automatic step(input bit hv, input logic [DW-1:0] hd, input bit det,
                       input bit cor, input logic [DW-1:0] mdo, input bit clr);
      host_valid    = hv;
      host_data     = hd;
      err_detected  = det;
      err_corrected = cor;
      mem_data_out  = mdo;
      fault_clr     = clr;
      #2;
      check_outputs();
      @(posedge clk);
      model_update(hv, det, cor, mdo, clr);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      rst_n         = 1'b0;
      host_valid    = 1'b0;
      host_data     = '0;
      err_detected  = 1'b0;
      err_corrected = 1'b0;
      mem_data_out  = '0;
      fault_clr     = 1'b0;
      model_reset();
      #7;
      check_outputs();
      #1 rst_n = 1'b1;

      // settle after reset, then a host write whose following flags are ignored
      idle(2);
      step(1'b1, 8'hA5, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1, 8'hFF, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 8'hFF, 1'b0);
      idle(1);

      // correctable error -> write-back; host stalls during WB
      step(1'b0, '0, 1'b1, 1'b1, 8'h3C, 1'b0);
      step(1'b1, 8'h11, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 8'h11, 1'b0, 1'b0, '0, 1'b0);
      idle(3);

      // uncorrectable error -> sticky fault; clear alone stays in fault mode
      step(1'b0, '0, 1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1, 8'h99, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1, 8'h99, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0, '0, 1'b0);
      idle(3);

      // host write and error flags in the same idle cycle
      step(1'b1, 8'h55, 1'b1, 1'b1, 8'h77, 1'b0);
      idle(3);

      // new fault coincident with fault_clr keeps fault set
      step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
      idle(1);
      step(1'b1, 8'h33, 1'b0, 1'b0, '0, 1'b0);
      idle(3);
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

      // reset asserted during a write-back drops mem_wr immediately
      step(1'b0, '0, 1'b1, 1'b1, 8'hC3, 1'b0);
      host_valid = 1'b0; err_detected = 1'b0; err_corrected = 1'b0;
      #1;
      check_outputs();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      #1 rst_n = 1'b1;
      idle(3);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) == 0, DW'($urandom), ($urandom % 3) == 0,
              ($urandom % 2) == 0, DW'($urandom), ($urandom % 16) == 0);
      end

      // long run of correctable errors: alarm threshold and saturation
      step(1'b1, 8'h01, 1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 1100; i++) begin
         step(1'b0, '0, 1'b1, 1'b1, DW'($urandom), 1'b0);
      end
      idle(2);
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/crc_mem_scrubber.md
Name: crc_mem_scrubber

Overview:
- Write-side controller placed directly upstream of the CRC-protected memory stage.
- Drives that stage's write port (mem_wr, mem_data_in) and monitors its read side (mem_data_out, err_detected, err_corrected).
- Arbitrates functional host writes against automatic scrub write-backs. When a correctable error is reported, the corrected word is written back so the stored data and CRC become clean again.
- Latches a sticky fault on uncorrectable errors, for the safety controller.

Parameters:
- DATA_WIDTH, 8, width of the data word; must match the memory stage.
- SETTLE_CYCLES, 2, cycles after any write during which error flags are ignored (covers the write-to-check latency of the memory stage); range 1..15.
- CNT_WIDTH, 8, width of the error counters (optional feature only).
- CORR_THRESH, 16, corrected-error count at which the alarm asserts (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- host_valid  in  1  host write request
- host_data  in  DATA_WIDTH  host write data
- host_ready  out  1  host write accepted when host_valid&host_ready
- mem_wr  out  1  write strobe to memory stage
- mem_data_in  out  DATA_WIDTH  write data to memory stage
- mem_data_out  in  DATA_WIDTH  corrected read data from memory stage
- err_detected  in  1  error flag from memory stage
- err_corrected  in  1  correction flag from memory stage
- fault_clr  in  1  clears sticky fault (and counters if feature enabled)
- fault  out  1  sticky uncorrectable-error flag
- scrub_busy  out  1  high in WB state
- corr_cnt  out  CNT_WIDTH  saturating corrected-error count (tied 0 without feature)
- uncorr_cnt  out  CNT_WIDTH  saturating uncorrectable-error count (tied 0 without feature)
- alarm  out  1  corr_cnt >= CORR_THRESH (tied 0 without feature)

Behaviour:
- Reset: state=SETTLE, settle_cnt=SETTLE_CYCLES, wb_data=0, fault=0, counters=0. mem_wr=0, mem_data_in=0, host_ready=1, scrub_busy=0, alarm=0.
- host_ready = (state != WB). host_fire = host_valid & host_ready.
- mem_wr = host_fire | (state==WB). mem_data_in = host_data on host_fire, wb_data in WB, otherwise 0. Combinational; zero added latency on host writes.
- FSM states: IDLE, WB, SETTLE, FAULT.
- Any state except WB, on host_fire: go to SETTLE, load settle_cnt=SETTLE_CYCLES. Host write always takes precedence over error handling in that cycle.
- SETTLE: decrement settle_cnt each cycle without host_fire; at 1 go to IDLE. Error flags are ignored.
- IDLE without host_fire:
  - err_detected&err_corrected: capture wb_data<=mem_data_out; go to WB.
  - err_detected&!err_corrected: set fault; go to FAULT.
  - err_corrected without err_detected: treated as no error.
- WB: exactly one cycle. mem_wr=1, host_ready=0, scrub_busy=1. Then go to SETTLE (settle_cnt=SETTLE_CYCLES).
- FAULT: error flags ignored; stays until host_fire (go to SETTLE). fault_clr alone does not leave FAULT.
- fault: sticky. fault_clr clears it; a new fault in the same cycle as fault_clr wins (fault stays 1).
- Reset mid-WB aborts the write-back immediately; mem_wr drops asynchronously.

Optional Feature:
- Macro CRC_SCRUB_ERR_CNT_EN.
- Defined:
  - corr_cnt increments on each IDLE->WB transition.
  - uncorr_cnt increments on each IDLE->FAULT transition.
  - Both saturate at all-ones.
  - fault_clr zeroes both; a clear and an increment in the same cycle yield 1.
  - alarm is registered: corr_cnt >= CORR_THRESH, one cycle after the count reaches it.
- Not defined: counter logic absent; corr_cnt, uncorr_cnt and alarm tied to 0.

Decomposition:
- Package crc_mem_pkg: state enum scrub_state_e {IDLE, WB, SETTLE, FAULT}; default width constants for data and counters.
- One natural sub-module: crc_err_counter (saturating counter with clear; instantiated twice under the macro).

Test Plan:
- Reset then idle, flags 0: host_ready=1, mem_wr=0, fault=0; state reaches IDLE after 2 cycles.
- host_valid=1, host_data=8'hA5 in IDLE: same-cycle mem_wr=1, mem_data_in=8'hA5. Flags forced high for the next 2 cycles are ignored; no WB.
- In IDLE, err_detected=err_corrected=1, mem_data_out=8'h3C: next cycle mem_wr=1, mem_data_in=8'h3C, host_ready=0, scrub_busy=1. A host_valid in that cycle stalls and is accepted the following cycle. With macro, corr_cnt=1.
- In IDLE, err_detected=1, err_corrected=0: fault=1 next cycle and sticky; flags ignored. fault_clr alone leaves state in FAULT. A host write goes to SETTLE then IDLE. With macro, uncorr_cnt=1.
- Error flags and host_valid (8'h55) in the same IDLE cycle: only the host write occurs (mem_data_in=8'h55), no WB, counters unchanged.
- Macro on, CORR_THRESH=16, 16 correctable events: alarm=1 one cycle after corr_cnt=16. Drive to saturation at 255, then fault_clr: counters return to 0 and alarm drops.
